// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one port of a dual-port SRAM (synchronous write, registered read)
//   between NUM_REQ requesters. At most one request is granted per cycle.
//   The granted command is registered onto the SRAM port.
//   Read data comes back on a single response channel, tagged with the
//   requester id.
//
//   Optional feature macro: SRAM_ARB_RR_EN
//     defined   -> round-robin arbitration with a priority pointer
//     undefined -> fixed priority (lowest index wins, no pointer)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   hold                blocks new grants; in-flight commands/responses finish
//   req_valid/we        per-requester valid and write(1)/read(0)
//   req_addr/wdata      flattened per-requester address / write data
//   req_ready           one-hot grant (combinational)
//   mem_en/we/addr/din  registered SRAM port command
//   mem_dout            SRAM read data (valid after the edge sampling the read)
//   rsp_valid/id/rdata  read response (one-cycle pulse, no backpressure)
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hold,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  input  logic [DATA_WIDTH-1:0]            mem_dout,
  output logic                             rsp_valid,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic [DATA_WIDTH-1:0]            rsp_rdata
);

  logic [NUM_REQ-1:0]    pick_vec;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic                  accept;
  logic                  sel_we;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ID_WIDTH-1:0]   cmd_id_reg;

  logic [ID_WIDTH-1:0]   id_terms   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_terms [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_terms[NUM_REQ];

`ifdef SRAM_ARB_RR_EN
  // Round-robin: requesters above the pointer are searched first; if none
  // of them is valid, the search wraps to the lowest valid index.
  logic [ID_WIDTH-1:0] ptr_reg;
  logic [NUM_REQ-1:0]  rr_mask;
  logic [NUM_REQ-1:0]  rr_masked;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rr_mask
      assign rr_mask[gi] = (ID_WIDTH'(gi) > ptr_reg);
    end
  endgenerate

  assign rr_masked = req_valid & rr_mask;
  assign pick_vec  = (|rr_masked) ? rr_masked : req_valid;

  // Pointer starts at NUM_REQ-1 so requester 0 wins first after reset;
  // it only moves on an accepted transfer, so hold freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= ID_WIDTH'(NUM_REQ - 1);
    end else if (accept) begin
      ptr_reg <= gnt_id;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  assign pick_vec = req_valid;
`endif

  // Isolate the lowest set bit (two's complement trick).
  assign gnt_oh    = pick_vec & (~pick_vec + NUM_REQ'(1));
  assign req_ready = (rst || hold) ? '0 : gnt_oh;
  assign accept    = |req_ready;
  assign sel_we    = |(req_ready & req_we);

  // AND-OR multiplexers driven by the one-hot grant.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign id_terms[gi]    = gnt_oh[gi] ? ID_WIDTH'(gi) : '0;
      assign addr_terms[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{gnt_oh[gi]}};
      assign wdata_terms[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_oh[gi]}};
    end
  endgenerate

  always_comb begin
    gnt_id    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_id    = gnt_id | id_terms[i];
      sel_addr  = sel_addr | addr_terms[i];
      sel_wdata = sel_wdata | wdata_terms[i];
    end
  end

  // Command stage followed by the response flag: a read command on the
  // port at edge N+1 becomes rsp_valid for the following cycle, exactly
  // when the SRAM presents its registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      cmd_id_reg <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept & sel_we;
      if (accept) begin
        mem_addr   <= sel_addr;
        mem_din    <= sel_wdata;
        cmd_id_reg <= gnt_id;
      end
      rsp_valid <= mem_en & ~mem_we;
      if (mem_en && !mem_we) begin
        rsp_id <= cmd_id_reg;
      end
    end
  end

  assign rsp_rdata = mem_dout;

endmodule
